branch_predictor: RTL and testbench

- Gshare conditional-branch direction predictor feeding the fetch side of the pipelined RV32I datapath.
- At fetch it indexes a pattern history table (PHT) of 2-bit saturating counters with PC xor global history (GHR). It drives br_predicted and emits a state_word_t snapshot that travels IF/ID -> ID/EX -> EX/MEM.
- At resolve it consumes the EX/MEM snapshot plus the actual outcome. It produces mispredicted and trains the PHT/GHR.
- A post-reset init FSM sweeps the PHT so the table can map to RAM without a per-entry reset.

---
 rtl/branch_predictor_pkg.sv | 11 +
 rtl/branch_predictor_pht_ram.sv | 22 ++
 rtl/branch_predictor.sv | 88 ++++++++
 tb/tb_branch_predictor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared types and default sizes for the gshare predictor
package branch_predictor_pkg;
  localparam int BP_IDX_BITS = 8;
  localparam int BP_GHR_BITS = 8;
  typedef struct packed {
    logic                   valid;
    logic                   pred;
    logic [BP_IDX_BITS-1:0] index;
  } state_word_t;
  typedef enum logic {BP_INIT, BP_RUN} bp_state_e;
endpackage

// File: rtl/branch_predictor_pht_ram.sv
// pht_ram: 2-bit counter table, async fetch/train reads, one sync write, no reset
//   raddr_i/rdata_o   fetch-side read
//   taddr_i/tdata_o   training-side read of the entry about to be rewritten
//   we_i/waddr_i/wdata_i  single write port (init sweep or training)
module pht_ram #(
  parameter int IDX_BITS = 8
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] raddr_i,
  output logic [1:0]          rdata_o,
  input  logic [IDX_BITS-1:0] taddr_i,
  output logic [1:0]          tdata_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] waddr_i,
  input  logic [1:0]          wdata_i
);
  logic [1:0] mem_q [2**IDX_BITS];
  assign rdata_o = mem_q[raddr_i];
  assign tdata_o = mem_q[taddr_i];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor with post-reset PHT init sweep
//   fetch_pc/fetch_valid -> br_predicted, state_out (snapshot for IF/ID)
//   exmem_state/br_mem/update -> mispredicted, PHT/GHR training
//   ready, br_count, mispred_count: status
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int GHR_BITS = BP_GHR_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        br_predicted,
  output state_word_t state_out,
  input  state_word_t exmem_state,
  input  logic        br_mem,
  input  logic        update,
  output logic        mispredicted,
  output logic        ready,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);
  bp_state_e           state_q, state_d;
  logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         br_count_q, br_count_d, mispred_count_q, mispred_count_d;
  logic [IDX_BITS-1:0] idx, waddr;
  logic [1:0]          fetch_ctr, train_ctr, ctr_nxt, wdata;
  logic                train, we;
  logic                unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};
  assign idx           = fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign ready         = state_q == BP_RUN;
  assign br_predicted  = ready && fetch_ctr[1];
  assign state_out     = '{valid: fetch_valid, pred: br_predicted, index: idx};
  assign mispredicted  = exmem_state.valid && (exmem_state.pred != br_mem);
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
  assign train         = ready && update;
  // training always rewrites the entry recorded at fetch, not a recomputed index
  assign ctr_nxt = br_mem ? (&train_ctr ? train_ctr : train_ctr + 2'd1)
                          : (|train_ctr ? train_ctr - 2'd1 : train_ctr);
  assign we    = rst && (!ready || train);
  assign waddr = ready ? exmem_state.index : init_idx_q;
  assign wdata = ready ? ctr_nxt : 2'b01;
  pht_ram #(.IDX_BITS(IDX_BITS)) u_pht (
    .clk     (clk),
    .raddr_i (idx),
    .rdata_o (fetch_ctr),
    .taddr_i (exmem_state.index),
    .tdata_o (train_ctr),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata)
  );
  always_comb begin
    state_d         = state_q;
    init_idx_d      = init_idx_q;
    ghr_d           = ghr_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (state_q == BP_INIT) begin
      init_idx_d = init_idx_q + 1'b1;
      state_d    = &init_idx_q ? BP_RUN : BP_INIT;
    end else if (train) begin
      ghr_d           = {ghr_q[GHR_BITS-2:0], br_mem};
      br_count_d      = br_count_q + 32'd1;
      mispred_count_d = mispred_count_q + {31'b0, mispredicted};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= BP_INIT;
      init_idx_q      <= '0;
      ghr_q           <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      state_q         <= state_d;
      init_idx_q      <= init_idx_d;
      ghr_q           <= ghr_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized self-checking bench against a table-level gshare model
module tb_branch_predictor;
  import branch_predictor_pkg::*;
  logic        clk = 0, rst = 0, fetch_valid = 0, br_mem = 0, update = 0;
  logic [31:0] fetch_pc = 0;
  state_word_t exmem_state = '0;
  logic        br_predicted, mispredicted, ready;
  state_word_t state_out;
  logic [31:0] br_count, mispred_count;
  int          checks = 0, failures = 0;
  int          m_pht [256];
  logic        m_ready = 0;
  int          m_init = 0;
  logic [7:0]  m_ghr = 0;
  logic [31:0] m_bc = 0, m_mc = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .br_predicted(br_predicted), .state_out(state_out), .exmem_state(exmem_state),
    .br_mem(br_mem), .update(update), .mispredicted(mispredicted), .ready(ready),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && update) assert (exmem_state.valid) else $error("update with invalid snapshot");

  function automatic logic [31:0] pc_for(input logic [7:0] e);
    return {22'b0, e ^ m_ghr, 2'b00};
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    logic [7:0] i;
    i = pc[9:2] ^ m_ghr;
    return m_ready && (m_pht[i] >= 2);
  endfunction

  task automatic tick();
    if (!rst) begin
      m_ready = 0; m_init = 0; m_ghr = 0; m_bc = 0; m_mc = 0;
    end else if (!m_ready) begin
      m_pht[m_init] = 1;
      m_init++;
      if (m_init == 256) m_ready = 1;
    end else if (update) begin
      int c;
      c = m_pht[exmem_state.index];
      m_pht[exmem_state.index] = br_mem ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
      if (exmem_state.valid && exmem_state.pred != br_mem) m_mc++;
      m_bc++;
      m_ghr = {m_ghr[6:0], br_mem};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    rst = 1;
    for (int i = 0; i < 255; i++) begin
      fetch_pc = $urandom;
      tick();
      checks++;
      if (ready !== 1'b0 || br_predicted !== 1'b0) begin
        failures++;
        $display("FAIL sweep_edge%0d ready=%b pred=%b want 0/0", i + 1, ready, br_predicted);
      end
    end
    tick();
    checks++;
    if (ready !== m_ready || ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_256 got=%b want=1", ready);
    end
    checks++;
    if (br_count !== 0 || mispred_count !== 0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d want 0/0", br_count, mispred_count);
    end
    for (int i = 0; i < 8; i++) begin
      fetch_pc = $urandom;
      #1;
      checks++;
      if (br_predicted !== 1'b0) begin
        failures++; $display("FAIL post_sweep_pred pc=%h got=%b want=0", fetch_pc, br_predicted);
      end
    end
  endtask

  task automatic test_single_train();
    exmem_state = '{valid: 1'b1, pred: 1'b0, index: 8'h40};
    br_mem = 1; update = 1; fetch_pc = $urandom;
    #1;
    checks++;
    if (mispredicted !== 1'b1) begin
      failures++; $display("FAIL single_mispred got=%b want=1", mispredicted);
    end
    tick();
    update = 0; fetch_pc = 0;
    #1;
    checks++;
    if (state_out.index !== 8'h01 || m_ghr !== 8'h01) begin
      failures++; $display("FAIL single_ghr got=%h want=01", state_out.index);
    end
    fetch_pc = 32'h104;
    #1;
    checks++;
    if (br_predicted !== 1'b1) begin
      failures++; $display("FAIL single_pred got=%b want=1", br_predicted);
    end
    checks++;
    if (br_count !== 1 || mispred_count !== 1) begin
      failures++; $display("FAIL single_counts got=%0d/%0d want 1/1", br_count, mispred_count);
    end
  endtask

  task automatic test_saturation();
    logic [4:0] dirs;
    logic [4:0] want;
    dirs = 5'b11110;
    want = 5'b11110;
    for (int k = 0; k < 6; k++) begin
      logic d, w;
      d = (k < 4) ? 1'b1 : 1'b0;
      w = (k < 5) ? 1'b1 : 1'b0;
      fetch_pc = pc_for(8'h10);
      exmem_state = '{valid: 1'b1, pred: m_pred(pc_for(8'h10)), index: 8'h10};
      br_mem = d; update = 1;
      tick();
      update = 0;
      fetch_pc = pc_for(8'h10);
      #1;
      checks++;
      if (br_predicted !== w || br_predicted !== m_pred(fetch_pc)) begin
        failures++; $display("FAIL saturation_step%0d got=%b want=%b", k, br_predicted, w);
      end
    end
    checks++;
    if (m_pht[8'h10] != 1 || dirs !== want) begin
      failures++; $display("FAIL saturation_model_state got=%0d want=1", m_pht[8'h10]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] bc, mc;
    logic [7:0] g;
    bc = br_count; mc = mispred_count; g = m_ghr;
    exmem_state = '{valid: 1'b1, pred: 1'b1, index: 8'h22};
    br_mem = 0; update = 0;
    for (int k = 0; k < 5; k++) begin
      fetch_pc = pc_for(8'h22);
      #1;
      checks++;
      if (mispredicted !== 1'b1) begin
        failures++; $display("FAIL stall_mispred cyc%0d got=%b want=1", k, mispredicted);
      end
      tick();
      fetch_pc = 0;
      #1;
      checks++;
      if (state_out.index !== g || br_count !== bc || mispred_count !== mc) begin
        failures++;
        $display("FAIL stall_hold cyc%0d ghr=%h cnt=%0d/%0d want %h %0d/%0d",
                 k, state_out.index, br_count, mispred_count, g, bc, mc);
      end
      fetch_pc = pc_for(8'h22);
      #1;
      checks++;
      if (br_predicted !== m_pred(fetch_pc)) begin
        failures++; $display("FAIL stall_pht cyc%0d got=%b want=%b", k, br_predicted, m_pred(fetch_pc));
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] e;
    e = 8'h10;
    fetch_pc = pc_for(e);
    exmem_state = '{valid: 1'b1, pred: 1'b0, index: e};
    br_mem = 1; update = 1;
    #1;
    checks++;
    if (br_predicted !== 1'b0 || state_out.index !== e) begin
      failures++; $display("FAIL collision_same_cycle pred=%b idx=%h want 0 %h", br_predicted, state_out.index, e);
    end
    tick();
    update = 0;
    fetch_pc = pc_for(e);
    #1;
    checks++;
    if (br_predicted !== 1'b1) begin
      failures++; $display("FAIL collision_next_cycle got=%b want=1", br_predicted);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      logic [7:0] ti;
      fetch_pc = $urandom;
      fetch_valid = $urandom_range(0, 1);
      ti = 8'($urandom_range(0, 15)) ^ m_ghr;
      exmem_state = '{valid: 1'b1, pred: ($urandom_range(0, 3) == 0) ? 1'b1 : m_pred(pc_for(ti)), index: ti};
      br_mem = $urandom_range(0, 1);
      update = $urandom_range(0, 3) != 0;
      #1;
      checks++;
      if (br_predicted !== m_pred(fetch_pc) || state_out.valid !== fetch_valid
          || state_out.pred !== m_pred(fetch_pc) || state_out.index !== (fetch_pc[9:2] ^ m_ghr)) begin
        failures++;
        $display("FAIL random_fetch cyc%0d pred=%b idx=%h want %b %h", k, br_predicted,
                 state_out.index, m_pred(fetch_pc), fetch_pc[9:2] ^ m_ghr);
      end
      checks++;
      if (mispredicted !== (exmem_state.pred != br_mem)) begin
        failures++; $display("FAIL random_mispred cyc%0d got=%b want=%b", k, mispredicted, exmem_state.pred != br_mem);
      end
      tick();
      checks++;
      if (br_count !== m_bc || mispred_count !== m_mc) begin
        failures++;
        $display("FAIL random_counts cyc%0d got=%0d/%0d want %0d/%0d", k, br_count, mispred_count, m_bc, m_mc);
      end
    end
    update = 0; fetch_valid = 0;
  endtask

  task automatic test_reset_mid();
    fetch_pc = 0;
    rst = 0;
    tick();
    rst = 1;
    #1;
    checks++;
    if (ready !== 1'b0 || state_out.index !== 8'h00 || br_count !== 0 || mispred_count !== 0) begin
      failures++;
      $display("FAIL midrun_reset ready=%b ghr=%h cnt=%0d/%0d want 0 00 0/0",
               ready, state_out.index, br_count, mispred_count);
    end
    for (int i = 0; i < 255; i++) begin
      tick();
      checks++;
      if (ready !== 1'b0) begin
        failures++; $display("FAIL midrun_sweep edge%0d ready=%b want=0", i + 1, ready);
      end
    end
    tick();
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL midrun_ready got=%b want=1", ready);
    end
    for (int e = 0; e < 256; e++) begin
      fetch_pc = pc_for(8'(e));
      #1;
      checks++;
      if (br_predicted !== 1'b0) begin
        failures++; $display("FAIL midrun_entry%0d got=%b want=0", e, br_predicted);
      end
      tick();
    end
    exmem_state = '{valid: 1'b1, pred: 1'b0, index: 8'h40};
    br_mem = 1; update = 1;
    tick();
    update = 0;
    fetch_pc = pc_for(8'h40);
    #1;
    checks++;
    if (br_predicted !== 1'b1 || br_predicted !== m_pred(fetch_pc)) begin
      failures++; $display("FAIL midrun_retrain got=%b want=1", br_predicted);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    test_reset();
    test_single_train();
    test_saturation();
    test_stall();
    test_collision();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
